btn_cmd_arbiter: RTL
====================

Name: btn_cmd_arbiter

Overview:
- Shares one downstream command consumer among N pushbutton channels.
- Each channel's debounced, synchronized, edge-detected single-cycle pulse feeds one req_pulse bit.
- Per-channel events are latched as pending, granted round-robin, and presented as a valid/ready command carrying the channel index.
- A programmable hold-off between commands paces the consumer (display/game FSM); dropped presses are flagged per channel.

Parameters:
- N, 4: number of button channels (2..8).
- IDW, 2: width of cmd_id; must equal clog2(N).
- HOLD, 8: minimum idle cycles in HOLD state after each accepted command (0..65535).

Ports:
- clk  input  1  single clock; all inputs synchronous to it; req pulses are one cycle wide in this domain.
- rst  input  1  asynchronous, active-low reset.
- req_pulse  input  N  one-cycle press events, bit i = channel i.
- cmd_ready  input  1  consumer accepts command when high together with cmd_valid.
- ovf_clr  input  1  one-cycle pulse, clears all ovf bits.
- cmd_valid  output  1  command offered.
- cmd_id  output  IDW  granted channel index; stable while cmd_valid=1.
- ovf  output  N  sticky per-channel "press dropped" flags.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=0, async): cmd_valid=0, cmd_id=0, ovf=0, pending=0, busy=0, state=IDLE, hold counter=0, last-grant pointer=N-1 (first search starts at channel 0). Outputs go low immediately, without waiting for a clock edge.
- Pending latch: req_pulse[i]=1 at an edge sets pending[i]. If pending[i] is already 1 and not being cleared that edge, ovf[i] is set and the event is dropped (no counting).
- Grant at edge while pending[winner] is cleared and req_pulse[winner]=1 in the same cycle: pending[winner] stays 1 (new event), no overflow.
- ovf: set and ovf_clr on the same edge for bit i → set wins; other bits clear.
- Round-robin: search order starts at (last+1) mod N and wraps; the first pending channel wins; last <= winner on grant.
- FSM states: IDLE, OFFER, HOLD.
  - IDLE: if any pending at the edge → OFFER, with cmd_valid<=1, cmd_id<=winner, pending[winner] cleared. Otherwise remain IDLE.
  - OFFER: cmd_valid and cmd_id held constant. If cmd_ready=1 at an edge (handshake) → cmd_valid<=0. Then go to HOLD with counter<=HOLD if HOLD>0, else go to IDLE.
  - HOLD: counter decrements each edge; at counter==1 → IDLE. State is occupied for exactly HOLD cycles.
- Latency: pulse sampled at edge t → pending at t; cmd_valid high after edge t+1 (if IDLE).
- Minimum gap: cmd_valid is low for HOLD+1 cycles between commands (HOLD cycles + one IDLE cycle).
- cmd_ready while cmd_valid=0 is ignored. Pulses arriving in OFFER/HOLD are only latched, never granted early.
- No combinational path from inputs to outputs; all outputs registered.

Test Plan:
- Reset: drive rst=0 mid-simulation with random stimulus → cmd_valid=0, ovf=4'b0000, busy=0 immediately. After release with no pulses, no command for 50 cycles.
- Single press (HOLD=2): req_pulse=4'b0100 at edge 10, cmd_ready=1 → cmd_valid high after edge 11, cmd_id=2, handshake at edge 12. cmd_valid low for 3 cycles, busy high for edges 11–14.
- Simultaneous presses: req_pulse=4'b1011 in one cycle, cmd_ready=1, HOLD=2 → cmd_id sequence 0,1,3. Each cmd_valid is one cycle, separated by 3 low cycles. No ovf.
- Back-pressure/overflow: cmd_ready=0 for 6 cycles during OFFER id=1 → cmd_valid and cmd_id=1 stable. Two pulses on channel 3 during that window → ovf=4'b1000. ovf_clr → ovf=0. A coincident pulse with ovf_clr keeps the bit set.
- Fairness: channels 0 and 1 pulse every cycle, cmd_ready=1 → grants alternate 0,1,0,1 for 8 commands. Channel 1 never starved.
- Grant/pulse collision: req_pulse[0]=1 on the same edge channel 0 is granted → a second command with id 0 follows after the hold-off, ovf[0]=0.

Source files
------------

// File: rtl/btn_cmd_arbiter_if.sv
// Command handshake between the button arbiter (master) and its consumer (slave).
interface btn_cmd_arbiter_if #(
  parameter int unsigned IDW = 2
) ();
  logic           cmd_valid;
  logic           cmd_ready;
  logic [IDW-1:0] cmd_id;

  modport master (output cmd_valid, output cmd_id, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_id, output cmd_ready);
endinterface

// File: rtl/btn_cmd_arbiter.sv
// Latches per-channel button pulses, grants them round-robin as valid/ready
// commands and paces the consumer with a fixed hold-off after each handshake.
module btn_cmd_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned IDW  = 2,
  parameter int unsigned HOLD = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N-1:0]             req_pulse,
  input  logic                     ovf_clr,
  output logic [N-1:0]             ovf,
  output logic                     busy,
  btn_cmd_arbiter_if.master        cmd
);

  localparam int unsigned  CW       = 16;
  localparam logic [CW-1:0] HOLD_CNT = CW'(HOLD);

  typedef enum logic [1:0] {S_IDLE, S_OFFER, S_HOLD} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   pending_q, pending_d;
  logic [N-1:0]   ovf_q, ovf_d;
  logic [N-1:0]   clr_mask;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IDW-1:0] last_q, last_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] winner, cand;
  logic           valid_q, valid_d;
  logic           busy_q, busy_d;
  logic           found;

  // Round-robin search starting just after the last granted channel
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IDW'((32'(last_q) + k) % N);
      if (!found && pending_q[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    id_d     = id_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    clr_mask = '0;

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d          = S_OFFER;
          valid_d          = 1'b1;
          id_d             = winner;
          last_d           = winner;
          clr_mask[winner] = 1'b1;
        end
      end
      S_OFFER: begin
        if (cmd.cmd_ready) begin
          valid_d = 1'b0;
          if (HOLD > 0) begin
            state_d = S_HOLD;
            cnt_d   = HOLD_CNT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        if (cnt_q <= CW'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A pulse on a channel still pending (and not just granted) is dropped
    pending_d = (pending_q & ~clr_mask) | req_pulse;
    ovf_d     = (ovf_q & ~{N{ovf_clr}}) | (req_pulse & pending_q & ~clr_mask);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      ovf_q     <= '0;
      cnt_q     <= '0;
      last_q    <= IDW'(N - 1);
      id_q      <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      id_q      <= id_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign cmd.cmd_valid = valid_q;
  assign cmd.cmd_id    = id_q;
  assign ovf           = ovf_q;
  assign busy          = busy_q;

endmodule
